// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller.
// The divider path is compiled in only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
        ST_DIV  = 2'd2,
`endif
        ST_WB   = 2'd3
    } state_e;

    localparam int MUL_LAT  = 2;
    localparam int DIV_ITER = 32;

    // Without the divider, DIV/DIVU fall into the illegal-op path.
    function automatic logic op_legal(input logic [2:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO: ok = 1'b1;
`ifdef MULDIV_DIV_EN
            OP_DIV, OP_DIVU:                     ok = 1'b1;
`endif
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Radix-2 restoring unsigned 32-bit divider, one quotient bit per cycle.
// Present only in builds with MULDIV_DIV_EN defined.
`ifdef MULDIV_DIV_EN
module muldiv_div_iter
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic [32:0] trial;

    // Shifted partial remainder never exceeds 2*divisor-1, so bit 32 is the borrow.
    assign trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};

    always_comb begin
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        done_d   = 1'b0;
        if (flush_i) begin
            active_d = 1'b0;
        end else if (start_i) begin
            quo_d    = dividend_i;
            rem_d    = 32'd0;
            dvs_d    = divisor_i;
            cnt_d    = 6'd0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (!trial[32]) begin
                rem_d = trial[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = {rem_q[30:0], quo_q[31]};
                quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(DIV_ITER - 1)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q    <= 32'd0;
            rem_q    <= 32'd0;
            dvs_q    <= 32'd0;
            cnt_q    <= 6'd0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign done_o      = done_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule
`endif

// File: rtl/muldiv_ctrl.sv
// MIPS-style HI/LO multiply/divide controller with one-cycle writeback strobe.
// Define MULDIV_DIV_EN to include DIV/DIVU; otherwise they report illegal.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        cancel,
    input  logic [31:0] cur_hi,
    input  logic [31:0] cur_lo,
    output logic        busy,
    output logic        hilo_we,
    output logic [31:0] hilo_hi,
    output logic [31:0] hilo_lo,
    output logic        illegal
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        illegal_q, illegal_d;
    logic        accept;
    logic [63:0] a_ext, b_ext, product;

    assign req_ready = (state_q == ST_IDLE) & ~cancel;
    assign busy      = (state_q != ST_IDLE);
    assign accept    = req_valid & req_ready;
    assign illegal   = illegal_q;

    // Sign- or zero-extending to 64 bits lets one multiplier serve MULT and MULTU.
    assign a_ext   = (op_q == OP_MULT) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign b_ext   = (op_q == OP_MULT) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign product = a_ext * b_ext;

    // MTHI/MTLO pass the untouched half straight through from the live register.
    assign hilo_hi = (state_q == ST_WB && op_q == OP_MTLO) ? cur_hi : res_hi_q;
    assign hilo_lo = (state_q == ST_WB && op_q == OP_MTHI) ? cur_lo : res_lo_q;

`ifdef MULDIV_DIV_EN
    logic        dz_q, dz_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic        div_start, div_flush, div_done;
    logic        sgn_div;
    logic [31:0] mag_a, mag_b, div_quo, div_rem;

    assign sgn_div = (req_op == OP_DIV);
    assign mag_a   = (sgn_div && req_a[31]) ? -req_a : req_a;
    assign mag_b   = (sgn_div && req_b[31]) ? -req_b : req_b;

    muldiv_div_iter u_div (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_start),
        .flush_i     (div_flush),
        .dividend_i  (mag_a),
        .divisor_i   (mag_b),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        illegal_d = 1'b0;
        hilo_we   = 1'b0;
`ifdef MULDIV_DIV_EN
        dz_d      = dz_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        div_start = 1'b0;
        div_flush = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!op_legal(req_op)) begin
                        illegal_d = 1'b1;
                    end else begin
                        op_d = op_e'(req_op);
                        a_d  = req_a;
                        b_d  = req_b;
                        case (op_e'(req_op))
                            OP_MULT, OP_MULTU: state_d = ST_MUL;
                            OP_MTHI: begin
                                res_hi_d = req_a;
                                state_d  = ST_WB;
                            end
                            OP_MTLO: begin
                                res_lo_d = req_a;
                                state_d  = ST_WB;
                            end
`ifdef MULDIV_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                state_d = ST_DIV;
                                dz_d    = (req_b == 32'd0);
                                negq_d  = sgn_div & (req_a[31] ^ req_b[31]);
                                negr_d  = sgn_div & req_a[31];
                                if (req_b == 32'd0) begin
                                    res_lo_d = 32'hFFFF_FFFF;
                                    res_hi_d = req_a;
                                end else begin
                                    div_start = 1'b1;
                                end
                            end
`endif
                            default: state_d = ST_IDLE;
                        endcase
                    end
                end
            end
            ST_MUL: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    res_hi_d = product[63:32];
                    res_lo_d = product[31:0];
                    state_d  = ST_WB;
                end
            end
`ifdef MULDIV_DIV_EN
            // Divide-by-zero results were loaded at acceptance; just wait one cycle.
            ST_DIV: begin
                if (cancel) begin
                    state_d   = ST_IDLE;
                    div_flush = 1'b1;
                end else if (dz_q) begin
                    state_d = ST_WB;
                end else if (div_done) begin
                    res_lo_d = negq_q ? -div_quo : div_quo;
                    res_hi_d = negr_q ? -div_rem : div_rem;
                    state_d  = ST_WB;
                end
            end
`endif
            ST_WB: begin
                hilo_we = ~cancel;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MULT;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            res_hi_q  <= 32'd0;
            res_lo_q  <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_hi_q  <= res_hi_d;
            res_lo_q  <= res_lo_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef MULDIV_DIV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dz_q   <= 1'b0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else begin
            dz_q   <= dz_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
        end
    end
`endif

endmodule
